// File: rtl/hdmi_pattern_gen.sv
// HDMI test-pattern source: Wishbone registers, shadowed working set, DE raster and colour-A frame counter.
// Optional build macro HDMIGEN_LFSR_EN turns mode 3 into a 30-bit pseudo-random pattern instead of a ramp.
module hdmi_pattern_gen #(
  parameter int CW       = 12,
  parameter int H_ACTIVE = 640,
  parameter int H_TOTAL  = 800,
  parameter int V_ACTIVE = 480,
  parameter int V_TOTAL  = 525
) (
  input  logic        i_clk,
  input  logic        i_areset_n,
  input  logic        i_wb_cyc,
  input  logic        i_wb_stb,
  input  logic        i_wb_we,
  input  logic [1:0]  i_wb_addr,
  input  logic [31:0] i_wb_data,
  output logic        o_wb_ack,
  output logic        o_wb_stall,
  output logic [31:0] o_wb_data,
  output logic [9:0]  o_hdmi_r,
  output logic [9:0]  o_hdmi_g,
  output logic [9:0]  o_hdmi_b,
  output logic        o_de,
  output logic        o_sof
);

  localparam logic [CW-1:0] H_ACT  = CW'(H_ACTIVE);
  localparam logic [CW-1:0] V_ACT  = CW'(V_ACTIVE);
  localparam logic [CW-1:0] H_LAST = CW'(H_TOTAL - 1);
  localparam logic [CW-1:0] V_LAST = CW'(V_TOTAL - 1);
  localparam logic [CW-1:0] CNT_ONE = CW'(1);

  // Live registers (bus side)
  logic [29:0] col_a;
  logic [29:0] col_b;
  logic        ctl_en;
  logic [11:0] ctl_barw;
  logic [1:0]  ctl_mode;
  logic [31:0] frame_count;

  // Working set (raster side)
  logic [29:0] w_a;
  logic [29:0] w_b;
  logic        w_en;
  logic [11:0] w_barw;
  logic [1:0]  w_mode;

  logic [CW-1:0] h;
  logic [CW-1:0] v;
  logic [11:0]   hbar;
  logic [11:0]   vbar;
  logic          hphase;
  logic          vphase;
  logic [31:0]   acount;

  logic          run;
  logic          h_last;
  logic          v_last;
  logic          wrap;
  logic          load;
  logic          active;
  logic [11:0]   barw_end;
  logic [29:0]   pix;
  logic [31:0]   rd_next;
  logic          hit;
  logic [31:0]   acount_inc;
  logic          unused_bits;

  assign unused_bits = i_wb_data[30];
  assign o_wb_stall  = 1'b0;

  // A live disable stops the raster at once; everything else waits for the frame wrap.
  assign run      = w_en & ctl_en;
  assign h_last   = (h == H_LAST);
  assign v_last   = (v == V_LAST);
  assign wrap     = run & h_last & v_last;
  assign load     = ~w_en | ~ctl_en | wrap;
  assign active   = (h < H_ACT) && (v < V_ACT);
  assign barw_end = (w_barw == 12'd0) ? 12'd0 : (w_barw - 12'd1);

  // Bus handshake: every strobe is acked exactly one clock later and the bus never stalls;
  // read data is re-registered from the address each clock, writes take effect on the strobe edge.
  always_comb begin
    rd_next = '0;
    case (i_wb_addr)
      2'd0:    rd_next = {2'b00, col_a};
      2'd1:    rd_next = {2'b00, col_b};
      2'd2:    rd_next = {ctl_en, 3'b000, ctl_barw, 14'd0, ctl_mode};
      default: rd_next = frame_count;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_areset_n) begin
    if (!i_areset_n) begin
      o_wb_ack  <= 1'b0;
      o_wb_data <= '0;
      col_a     <= '0;
      col_b     <= '0;
      ctl_en    <= 1'b0;
      ctl_barw  <= '0;
      ctl_mode  <= '0;
    end else begin
      o_wb_ack  <= i_wb_stb;
      o_wb_data <= rd_next;
      if (i_wb_cyc && i_wb_stb && i_wb_we) begin
        case (i_wb_addr)
          2'd0: col_a <= i_wb_data[29:0];
          2'd1: col_b <= i_wb_data[29:0];
          2'd2: begin
            ctl_en   <= i_wb_data[31];
            ctl_barw <= i_wb_data[27:16];
            ctl_mode <= i_wb_data[1:0];
          end
          default: ;
        endcase
      end
    end
  end

  always_ff @(posedge i_clk or negedge i_areset_n) begin
    if (!i_areset_n) begin
      w_a    <= '0;
      w_b    <= '0;
      w_en   <= 1'b0;
      w_barw <= '0;
      w_mode <= '0;
    end else if (load) begin
      w_a    <= col_a;
      w_b    <= col_b;
      w_en   <= ctl_en;
      w_barw <= ctl_barw;
      w_mode <= ctl_mode;
    end
  end

  always_ff @(posedge i_clk or negedge i_areset_n) begin
    if (!i_areset_n) begin
      h <= '0;
      v <= '0;
    end else if (!run) begin
      h <= '0;
      v <= '0;
    end else begin
      h <= h_last ? '0 : (h + CNT_ONE);
      if (h_last) begin
        v <= v_last ? '0 : (v + CNT_ONE);
      end
    end
  end

  // Bar phases track (h / BARW) and (v / BARW) parity without a divider.
  always_ff @(posedge i_clk or negedge i_areset_n) begin
    if (!i_areset_n) begin
      hbar   <= '0;
      hphase <= 1'b0;
      vbar   <= '0;
      vphase <= 1'b0;
    end else if (!run) begin
      hbar   <= '0;
      hphase <= 1'b0;
      vbar   <= '0;
      vphase <= 1'b0;
    end else begin
      if (h_last) begin
        hbar   <= '0;
        hphase <= 1'b0;
        if (v_last) begin
          vbar   <= '0;
          vphase <= 1'b0;
        end else if (vbar == barw_end) begin
          vbar   <= '0;
          vphase <= ~vphase;
        end else begin
          vbar <= vbar + 12'd1;
        end
      end else if (h < H_ACT) begin
        if (hbar == barw_end) begin
          hbar   <= '0;
          hphase <= ~hphase;
        end else begin
          hbar <= hbar + 12'd1;
        end
      end
    end
  end

`ifdef HDMIGEN_LFSR_EN
  logic [29:0] lfsr;

  always_ff @(posedge i_clk or negedge i_areset_n) begin
    if (!i_areset_n) begin
      lfsr <= 30'h1;
    end else if (!run || wrap) begin
      lfsr <= 30'h1;
    end else if (active) begin
      lfsr <= {lfsr[28:0], lfsr[29] ^ lfsr[5] ^ lfsr[3] ^ lfsr[0]};
    end
  end
`endif

  always_comb begin
    pix = '0;
    case (w_mode)
      2'd0: pix = w_a;
      2'd1: pix = hphase ? w_b : w_a;
      2'd2: pix = (hphase ^ vphase) ? w_b : w_a;
      default: begin
`ifdef HDMIGEN_LFSR_EN
        pix = lfsr;
`else
        pix = {h[9:0], h[9:0], h[9:0]};
`endif
      end
    endcase
    if (!active) begin
      pix = '0;
    end
  end

  always_ff @(posedge i_clk or negedge i_areset_n) begin
    if (!i_areset_n) begin
      o_de     <= 1'b0;
      o_sof    <= 1'b0;
      o_hdmi_r <= '0;
      o_hdmi_g <= '0;
      o_hdmi_b <= '0;
    end else if (!run) begin
      o_de     <= 1'b0;
      o_sof    <= 1'b0;
      o_hdmi_r <= '0;
      o_hdmi_g <= '0;
      o_hdmi_b <= '0;
    end else begin
      o_de     <= active;
      o_sof    <= active && (h == '0) && (v == '0);
      o_hdmi_r <= pix[29:20];
      o_hdmi_g <= pix[19:10];
      o_hdmi_b <= pix[9:0];
    end
  end

  // Counts what actually left the output register, so it matches a downstream histogram.
  assign hit        = o_de && ({o_hdmi_r, o_hdmi_g, o_hdmi_b} == w_a);
  assign acount_inc = (hit && (acount != 32'hFFFF_FFFF)) ? (acount + 32'd1) : acount;

  always_ff @(posedge i_clk or negedge i_areset_n) begin
    if (!i_areset_n) begin
      acount      <= '0;
      frame_count <= '0;
    end else if (!run) begin
      acount <= '0;
    end else if (wrap) begin
      frame_count <= acount_inc;
      acount      <= '0;
    end else begin
      acount <= acount_inc;
    end
  end

endmodule

// File: tb/tb_hdmi_pattern_gen.sv
// Bench for hdmi_pattern_gen: frame-position reference model checked every cycle, plus literal frame counts.
module tb_hdmi_pattern_gen;

  localparam int HA    = 16;
  localparam int HT    = 20;
  localparam int VA    = 8;
  localparam int VT    = 10;
  localparam int FRAME = HT * VT;

  // Clock / reset
  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic        cyc, stb, we;
  logic [1:0]  addr;
  logic [31:0] wdata;
  logic        o_wb_ack, o_wb_stall;
  logic [31:0] o_wb_data;
  logic [9:0]  o_hdmi_r, o_hdmi_g, o_hdmi_b;
  logic        o_de, o_sof;
  logic [29:0] dut_pix;

  assign dut_pix = {o_hdmi_r, o_hdmi_g, o_hdmi_b};

  hdmi_pattern_gen #(
    .CW(12), .H_ACTIVE(HA), .H_TOTAL(HT), .V_ACTIVE(VA), .V_TOTAL(VT)
  ) dut (
    .i_clk(clk), .i_areset_n(rst_n),
    .i_wb_cyc(cyc), .i_wb_stb(stb), .i_wb_we(we), .i_wb_addr(addr), .i_wb_data(wdata),
    .o_wb_ack(o_wb_ack), .o_wb_stall(o_wb_stall), .o_wb_data(o_wb_data),
    .o_hdmi_r(o_hdmi_r), .o_hdmi_g(o_hdmi_g), .o_hdmi_b(o_hdmi_b),
    .o_de(o_de), .o_sof(o_sof)
  );

  int checks = 0;
  int failures = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  // Reference model: live/working register copies and a linear frame position
  logic [29:0] m_a, m_b, w_a, w_b;
  logic        m_en, w_en;
  logic [11:0] m_bw, w_bw;
  logic [1:0]  m_mode, w_mode;
  int          m_pos;
  logic [31:0] m_cnt, m_reg3, m_next;
  logic        e_de, e_sof, e_ack;
  logic [29:0] e_pix;
  logic [31:0] e_rd;
  logic        m_run, m_wrap, m_load, m_hit;

  function automatic logic [31:0] model_read(input logic [1:0] a);
    case (a)
      2'd0:    return {2'b00, m_a};
      2'd1:    return {2'b00, m_b};
      2'd2:    return {m_en, 3'b000, m_bw, 14'd0, m_mode};
      default: return m_reg3;
    endcase
  endfunction

  function automatic logic [29:0] pattern(input int x, input int y);
    int bwe;
    logic [9:0] xv;
    if (x >= HA || y >= VA) return '0;
    bwe = (w_bw == 12'd0) ? 1 : int'(w_bw);
    xv = x[9:0];
    case (w_mode)
      2'd0:    return w_a;
      2'd1:    return ((x / bwe) % 2 == 1) ? w_b : w_a;
      2'd2:    return (((x / bwe) + (y / bwe)) % 2 == 1) ? w_b : w_a;
      default: return {xv, xv, xv};
    endcase
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_a <= '0; m_b <= '0; m_en <= 1'b0; m_bw <= '0; m_mode <= '0;
      w_a <= '0; w_b <= '0; w_en <= 1'b0; w_bw <= '0; w_mode <= '0;
      m_pos <= 0; m_cnt <= '0; m_reg3 <= '0;
      e_de <= 1'b0; e_sof <= 1'b0; e_pix <= '0; e_ack <= 1'b0; e_rd <= '0;
    end else begin
      m_run  = w_en && m_en;
      m_wrap = m_run && (m_pos == FRAME - 1);
      m_load = !w_en || !m_en || m_wrap;
      m_hit  = e_de && (e_pix == w_a);
      m_next = (m_hit && m_cnt != 32'hFFFF_FFFF) ? m_cnt + 32'd1 : m_cnt;
      e_ack <= stb;
      e_rd  <= model_read(addr);
      if (!m_run) begin
        m_pos <= 0; e_de <= 1'b0; e_sof <= 1'b0; e_pix <= '0; m_cnt <= '0;
      end else begin
        e_pix <= pattern(m_pos % HT, m_pos / HT);
        e_de  <= ((m_pos % HT) < HA) && ((m_pos / HT) < VA);
        e_sof <= (m_pos == 0);
        m_pos <= (m_pos + 1) % FRAME;
        if (m_wrap) begin
          m_reg3 <= m_next;
          m_cnt  <= '0;
        end else begin
          m_cnt <= m_next;
        end
      end
      if (m_load) begin
        w_a <= m_a; w_b <= m_b; w_en <= m_en; w_bw <= m_bw; w_mode <= m_mode;
      end
      if (cyc && stb && we) begin
        case (addr)
          2'd0: m_a <= wdata[29:0];
          2'd1: m_b <= wdata[29:0];
          2'd2: begin m_en <= wdata[31]; m_bw <= wdata[27:16]; m_mode <= wdata[1:0]; end
          default: ;
        endcase
      end
    end
  end

  // Scoreboard compare every cycle, away from the active edge
  always @(negedge clk) begin
    check("de", 64'(o_de), 64'(e_de));
    check("sof", 64'(o_sof), 64'(e_sof));
    check("pixel", 64'(dut_pix), 64'(e_pix));
    check("ack", 64'(o_wb_ack), 64'(e_ack));
    check("stall", 64'(o_wb_stall), 64'd0);
    check("rdata", 64'(o_wb_data), 64'(e_rd));
  end

  // Driver tasks
  task automatic wb_write(input logic [1:0] a, input logic [31:0] d);
    @(negedge clk);
    cyc = 1'b1; stb = 1'b1; we = 1'b1; addr = a; wdata = d;
    @(negedge clk);
    cyc = 1'b0; stb = 1'b0; we = 1'b0;
  endtask

  task automatic wb_read(input logic [1:0] a, output logic [31:0] d);
    @(negedge clk);
    cyc = 1'b1; stb = 1'b1; we = 1'b0; addr = a;
    @(negedge clk);
    d = o_wb_data;
    cyc = 1'b0; stb = 1'b0;
  endtask

  task automatic wait_sof();
    int n;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!o_sof && n < 1000);
    if (!o_sof) check("sof_timeout", 64'(o_sof), 64'd1);
  endtask

  function automatic logic [31:0] ctrl(input bit en, input int bw, input int mode);
    return {en, 3'b000, 12'(bw), 14'd0, 2'(mode)};
  endfunction

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
    $fatal(1, "watchdog");
  end

  logic [31:0] rd;
  logic [29:0] ca, cb;
  int nde, n, op;

  initial begin
    rst_n = 1'b0; cyc = 1'b0; stb = 1'b0; we = 1'b0; addr = '0; wdata = '0;
    repeat (3) @(negedge clk);
    check("reset_de", 64'(o_de), 64'd0);
    check("reset_pix", 64'(dut_pix), 64'd0);
    check("reset_ack", 64'(o_wb_ack), 64'd0);
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      wb_read(2'(i), rd);
      check("reset_reg", 64'(rd), 64'd0);
    end

    // Mode 0: solid A
    ca = 30'h3FF00155;
    do cb = 30'($urandom); while (cb == ca);
    wb_write(2'd0, {2'b00, ca});
    wb_write(2'd1, {2'b00, cb});
    wb_write(2'd2, ctrl(1, 4, 0));
    wait_sof();
    check("m0_sof_pix", 64'(dut_pix), 64'h3FF00155);
    nde = 0;
    for (int i = 0; i < HT; i++) begin
      nde += int'(o_de);
      @(negedge clk);
    end
    check("m0_de_per_line", 64'(nde), 64'd16);
    wait_sof();
    wb_read(2'd3, rd);
    check("m0_count", 64'(rd), 64'd128);

    // Mode 1: vertical bars of 4
    wait_sof();
    wb_write(2'd2, ctrl(1, 4, 1));
    wait_sof();
    check("m1_pix0", 64'(dut_pix), 64'(ca));
    repeat (4) @(negedge clk);
    check("m1_pix4", 64'(dut_pix), 64'(cb));
    wait_sof();
    wb_read(2'd3, rd);
    check("m1_count", 64'(rd), 64'd64);

    // Mode 2: checkerboard of 2
    wb_write(2'd2, ctrl(1, 2, 2));
    wait_sof();
    repeat (2 * HT) @(negedge clk);
    check("m2_row2_start", 64'(dut_pix), 64'(cb));
    wait_sof();
    wb_read(2'd3, rd);
    check("m2_count", 64'(rd), 64'd64);

    // Mode 3: ramp with A = 0
    wb_write(2'd0, 32'd0);
    wb_write(2'd2, ctrl(1, 2, 3));
    wait_sof();
    repeat (5) @(negedge clk);
    check("m3_ramp5", 64'(dut_pix), 64'({10'd5, 10'd5, 10'd5}));
    wait_sof();
    wb_read(2'd3, rd);
    check("m3_count", 64'(rd), 64'd8);

    // Mid-frame change of A stays out of the current frame
    wait_sof();
    repeat (50) @(negedge clk);
    wb_write(2'd0, 32'h0001_2345);
    wait_sof();
    wb_read(2'd3, rd);
    check("midframe_old_a", 64'(rd), 64'd8);
    wait_sof();
    wb_read(2'd3, rd);
    check("midframe_new_a", 64'(rd), 64'd0);
    wb_write(2'd3, 32'hDEAD_BEEF);
    wb_read(2'd3, rd);
    check("reg3_read_only", 64'(rd), 64'd0);

    // Disable mid-frame keeps the last frame count
    wb_write(2'd0, {2'b00, ca});
    wb_write(2'd2, ctrl(1, 4, 1));
    wait_sof();
    wait_sof();
    wait_sof();
    repeat (30) @(negedge clk);
    wb_write(2'd2, ctrl(0, 4, 1));
    @(negedge clk);
    check("disable_de", 64'(o_de), 64'd0);
    check("disable_pix", 64'(dut_pix), 64'd0);
    wb_read(2'd3, rd);
    check("disable_keeps_count", 64'(rd), 64'd64);

    // Randomized traffic against the model
    for (int i = 0; i < 300; i++) begin
      op = $urandom_range(0, 9);
      if (op <= 2) begin
        wb_write(2'($urandom_range(0, 1)), $urandom);
      end else if (op == 3) begin
        wb_write(2'd2, ctrl($urandom_range(0, 5) != 0, $urandom_range(0, 5), $urandom_range(0, 3)));
      end else if (op == 4) begin
        wb_write(2'd3, $urandom);
      end else if (op <= 6) begin
        wb_read(2'($urandom_range(0, 3)), rd);
      end else begin
        repeat ($urandom_range(1, 40)) @(negedge clk);
      end
    end

    // Asynchronous reset at h=7, v=3
    wb_write(2'd0, {2'b00, ca});
    wb_write(2'd2, ctrl(1, 1, 0));
    wait_sof();
    wait_sof();
    repeat (66) @(posedge clk);
    #1 rst_n = 1'b0;
    #1;
    check("areset_de", 64'(o_de), 64'd0);
    check("areset_sof", 64'(o_sof), 64'd0);
    check("areset_pix", 64'(dut_pix), 64'd0);
    check("areset_rdata", 64'(o_wb_data), 64'd0);
    @(posedge clk);
    #3 rst_n = 1'b1;
    wb_read(2'd3, rd);
    check("areset_count", 64'(rd), 64'd0);
    wb_read(2'd2, rd);
    check("areset_ctrl", 64'(rd), 64'd0);
    wb_write(2'd0, {2'b00, ca});
    wb_write(2'd2, ctrl(1, 1, 0));
    n = 0;
    while (!o_de && n < 500) begin
      @(negedge clk);
      n++;
    end
    check("restart_de", 64'(o_de), 64'd1);
    check("restart_first_sof", 64'(o_sof), 64'd1);
    wait_sof();
    wait_sof();
    wb_read(2'd3, rd);
    check("restart_count", 64'(rd), 64'd128);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
